// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 8-bit CPU control path.
//   - opcode and ALU function code constants
//   - T-state / HALT encoding of the sequencer
//   - bit positions of the internal control word
//   - helpers for the idle word and ALU-opcode classification
package cpu_pkg;

   localparam int OPCODE_WIDTH = 4;
   localparam int FN_WIDTH     = 3;

   localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 4'h0;
   localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 4'h1;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'h2;
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'h3;
   localparam logic [OPCODE_WIDTH-1:0] OP_MUL = 4'h4;
   localparam logic [OPCODE_WIDTH-1:0] OP_DIV = 4'h5;
   localparam logic [OPCODE_WIDTH-1:0] OP_AND = 4'h6;
   localparam logic [OPCODE_WIDTH-1:0] OP_OR  = 4'h7;
   localparam logic [OPCODE_WIDTH-1:0] OP_STA = 4'h8;
   localparam logic [OPCODE_WIDTH-1:0] OP_OUT = 4'h9;
   localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 4'hA;
   localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = 4'hB;
   localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 4'hF;

   localparam logic [FN_WIDTH-1:0] FN_ADD  = 3'b000;
   localparam logic [FN_WIDTH-1:0] FN_SUB  = 3'b001;
   localparam logic [FN_WIDTH-1:0] FN_MUL  = 3'b010;
   localparam logic [FN_WIDTH-1:0] FN_DIV  = 3'b011;
   localparam logic [FN_WIDTH-1:0] FN_AND  = 3'b100;
   localparam logic [FN_WIDTH-1:0] FN_OR   = 3'b101;
   localparam logic [FN_WIDTH-1:0] FN_HOLD = 3'b110;

   typedef enum logic [2:0] {
      ST_T1   = 3'd0,
      ST_T2   = 3'd1,
      ST_T3   = 3'd2,
      ST_T4   = 3'd3,
      ST_T5   = 3'd4,
      ST_T6   = 3'd5,
      ST_HALT = 3'd6
   } state_t;

   // Control word: one bit per strobe, ALU function code in the top bits.
   localparam int CW_PC_OUT  = 0;
   localparam int CW_PC_INC  = 1;
   localparam int CW_PC_LOAD = 2;
   localparam int CW_MAR_IN  = 3;
   localparam int CW_RAM_OUT = 4;
   localparam int CW_RAM_IN  = 5;
   localparam int CW_IR_IN   = 6;
   localparam int CW_IR_OUT  = 7;
   localparam int CW_A_IN    = 8;
   localparam int CW_A_OUT   = 9;
   localparam int CW_B_IN    = 10;
   localparam int CW_ALU_EN  = 11;
   localparam int CW_OUT_IN  = 12;
   localparam int CW_FN_LSB  = 13;
   localparam int CW_WIDTH   = CW_FN_LSB + FN_WIDTH;

   typedef logic [CW_WIDTH-1:0] ctrl_word_t;

   // All strobes low, ALU told to hold its result.
   function automatic ctrl_word_t cw_idle();
      ctrl_word_t cw;
      cw = '0;
      cw[CW_FN_LSB +: FN_WIDTH] = FN_HOLD;
      return cw;
   endfunction

   function automatic logic is_alu_op(logic [OPCODE_WIDTH-1:0] op);
      return (op >= OP_ADD) && (op <= OP_OR);
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: bundle between the sequencer and the datapath.
//   inputs to sequencer : en, ir_opcode, a_zero
//   outputs to datapath : PC/MAR/RAM/IR/A/B/OUT strobes, alu_fn, alu_en, halted
//   master = sequencer side, slave = datapath side.
interface control_sequencer_if;
   import cpu_pkg::*;

   logic                    en;
   logic [OPCODE_WIDTH-1:0] ir_opcode;
   logic                    a_zero;
   logic                    pc_out;
   logic                    pc_inc;
   logic                    pc_load;
   logic                    mar_in;
   logic                    ram_out;
   logic                    ram_in;
   logic                    ir_in;
   logic                    ir_out;
   logic                    a_in;
   logic                    a_out;
   logic                    b_in;
   logic [FN_WIDTH-1:0]     alu_fn;
   logic                    alu_en;
   logic                    out_in;
   logic                    halted;

   modport master (
      input  en, ir_opcode, a_zero,
      output pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
             a_in, a_out, b_in, alu_fn, alu_en, out_in, halted
   );

   modport slave (
      output en, ir_opcode, a_zero,
      input  pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
             a_in, a_out, b_in, alu_fn, alu_en, out_in, halted
   );

endinterface

// File: rtl/control_decode.sv
// control_decode: combinational microcode ROM.
//   state  : current T-state / HALT
//   opcode : IR high nibble (only consulted in T3..T6)
//   a_zero : accumulator-zero flag (only consulted for JZ in T3)
//   cw     : control word (strobes + ALU function code)
// At most one bus-drive strobe is set in any entry.
module control_decode
   import cpu_pkg::*;
(
   input  state_t                  state,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    a_zero,
   output ctrl_word_t              cw
);

   logic [FN_WIDTH-1:0] alu_code;

   // ALU codes follow the opcode order starting at ADD.
   assign alu_code = FN_WIDTH'(opcode - OP_ADD);

   always_comb begin
      cw = cw_idle();
      case (state)
         ST_T1: begin
            cw[CW_PC_OUT] = 1'b1;
            cw[CW_MAR_IN] = 1'b1;
         end
         ST_T2: begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_IR_IN]   = 1'b1;
            cw[CW_PC_INC]  = 1'b1;
         end
         ST_T3: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_STA: begin
                  cw[CW_IR_OUT] = 1'b1;
                  cw[CW_MAR_IN] = 1'b1;
               end
               OP_OUT: begin
                  cw[CW_A_OUT]  = 1'b1;
                  cw[CW_OUT_IN] = 1'b1;
               end
               OP_JMP: begin
                  cw[CW_IR_OUT]  = 1'b1;
                  cw[CW_PC_LOAD] = 1'b1;
               end
               OP_JZ: begin
                  cw[CW_IR_OUT]  = a_zero;
                  cw[CW_PC_LOAD] = a_zero;
               end
               default: ;
            endcase
         end
         ST_T4: begin
            if (opcode == OP_LDA) begin
               cw[CW_RAM_OUT] = 1'b1;
               cw[CW_A_IN]    = 1'b1;
            end else if (opcode == OP_STA) begin
               cw[CW_A_OUT]  = 1'b1;
               cw[CW_RAM_IN] = 1'b1;
            end else if (is_alu_op(opcode)) begin
               cw[CW_RAM_OUT] = 1'b1;
               cw[CW_B_IN]    = 1'b1;
            end
         end
         ST_T5: begin
            // ALU registers its result at the end of this state.
            if (is_alu_op(opcode)) cw[CW_FN_LSB +: FN_WIDTH] = alu_code;
         end
         ST_T6: begin
            // Function held so the ALU output stays valid while A captures it.
            if (is_alu_op(opcode)) begin
               cw[CW_FN_LSB +: FN_WIDTH] = alu_code;
               cw[CW_ALU_EN]             = 1'b1;
               cw[CW_A_IN]               = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: T-state sequencer driving every datapath strobe.
//   clk : system clock, rising edge
//   clr : asynchronous active-high reset, forces T1 and idles all outputs
//   bus : control_sequencer_if.master (en, ir_opcode, a_zero in; strobes out)
// en=0 freezes the state and idles the outputs; the state's word reappears
// when en returns high.
module control_sequencer
   import cpu_pkg::*;
(
   input  logic                 clk,
   input  logic                 clr,
   control_sequencer_if.master  bus
);

   state_t     state_q;
   state_t     state_d;
   ctrl_word_t dec_cw;
   ctrl_word_t cw;

   control_decode u_decode (
      .state  (state_q),
      .opcode (bus.ir_opcode),
      .a_zero (bus.a_zero),
      .cw     (dec_cw)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) state_q <= ST_T1;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.en) begin
         case (state_q)
            ST_T1: state_d = ST_T2;
            ST_T2: state_d = ST_T3;
            ST_T3: begin
               if (bus.ir_opcode == OP_HLT)
                  state_d = ST_HALT;
               else if (bus.ir_opcode == OP_LDA || bus.ir_opcode == OP_STA ||
                        is_alu_op(bus.ir_opcode))
                  state_d = ST_T4;
               else
                  state_d = ST_T1;
            end
            ST_T4:   state_d = is_alu_op(bus.ir_opcode) ? ST_T5 : ST_T1;
            ST_T5:   state_d = ST_T6;
            ST_T6:   state_d = ST_T1;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_T1;
         endcase
      end
   end

   // clr idles outputs in the same cycle, not only after the state reset.
   always_comb begin
      cw = dec_cw;
      if (clr || !bus.en) cw = cw_idle();
   end

   assign bus.pc_out  = cw[CW_PC_OUT];
   assign bus.pc_inc  = cw[CW_PC_INC];
   assign bus.pc_load = cw[CW_PC_LOAD];
   assign bus.mar_in  = cw[CW_MAR_IN];
   assign bus.ram_out = cw[CW_RAM_OUT];
   assign bus.ram_in  = cw[CW_RAM_IN];
   assign bus.ir_in   = cw[CW_IR_IN];
   assign bus.ir_out  = cw[CW_IR_OUT];
   assign bus.a_in    = cw[CW_A_IN];
   assign bus.a_out   = cw[CW_A_OUT];
   assign bus.b_in    = cw[CW_B_IN];
   assign bus.alu_en  = cw[CW_ALU_EN];
   assign bus.out_in  = cw[CW_OUT_IN];
   assign bus.alu_fn  = cw[CW_FN_LSB +: FN_WIDTH];
   assign bus.halted  = (state_q == ST_HALT) && !clr;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

   logic clk = 1'b0;
   logic clr;
   int   errors = 0;
   int   checks = 0;

   control_sequencer_if cs_if ();

   control_sequencer dut (
      .clk (clk),
      .clr (clr),
      .bus (cs_if)
   );

   always #5 clk = ~clk;

   // Strobe masks in the order packed by obs().
   localparam logic [12:0] M_PC_OUT  = 13'h1000;
   localparam logic [12:0] M_PC_INC  = 13'h0800;
   localparam logic [12:0] M_PC_LOAD = 13'h0400;
   localparam logic [12:0] M_MAR_IN  = 13'h0200;
   localparam logic [12:0] M_RAM_OUT = 13'h0100;
   localparam logic [12:0] M_RAM_IN  = 13'h0080;
   localparam logic [12:0] M_IR_IN   = 13'h0040;
   localparam logic [12:0] M_IR_OUT  = 13'h0020;
   localparam logic [12:0] M_A_IN    = 13'h0010;
   localparam logic [12:0] M_A_OUT   = 13'h0008;
   localparam logic [12:0] M_B_IN    = 13'h0004;
   localparam logic [12:0] M_ALU_EN  = 13'h0002;
   localparam logic [12:0] M_OUT_IN  = 13'h0001;
   localparam logic [16:0] W_IDLE    = {1'b0, 3'b110, 13'h0};
   localparam logic [16:0] W_HALT    = {1'b1, 3'b110, 13'h0};

   function automatic logic [16:0] obs();
      return {cs_if.halted, cs_if.alu_fn, cs_if.pc_out, cs_if.pc_inc, cs_if.pc_load,
              cs_if.mar_in, cs_if.ram_out, cs_if.ram_in, cs_if.ir_in, cs_if.ir_out,
              cs_if.a_in, cs_if.a_out, cs_if.b_in, cs_if.alu_en, cs_if.out_in};
   endfunction

   // Reference: instruction length in enabled cycles, by opcode class.
   function automatic int instr_len(int op);
      if (op == 1 || op == 8) return 4;
      if (op >= 2 && op <= 7) return 6;
      return 3;
   endfunction

   // Reference: control word expected at step (1-based) of instruction op.
   function automatic logic [16:0] exp_word(int op, int step, bit az);
      logic [12:0] s  = 13'h0;
      logic [2:0]  fn = 3'b110;
      bit          alu = (op >= 2 && op <= 7);
      case (step)
         1: s = M_PC_OUT | M_MAR_IN;
         2: s = M_RAM_OUT | M_IR_IN | M_PC_INC;
         3: begin
            if (op == 1 || alu || op == 8) s = M_IR_OUT | M_MAR_IN;
            else if (op == 9)              s = M_A_OUT | M_OUT_IN;
            else if (op == 10)             s = M_IR_OUT | M_PC_LOAD;
            else if (op == 11 && az)       s = M_IR_OUT | M_PC_LOAD;
         end
         4: begin
            if (op == 1)      s = M_RAM_OUT | M_A_IN;
            else if (alu)     s = M_RAM_OUT | M_B_IN;
            else if (op == 8) s = M_A_OUT | M_RAM_IN;
         end
         5: fn = 3'(op - 2);
         6: begin
            fn = 3'(op - 2);
            s  = M_ALU_EN | M_A_IN;
         end
         default: ;
      endcase
      return {1'b0, fn, s};
   endfunction

   // Opcode/flag are don't-care during fetch, so they are scrambled there.
   task automatic drive_inputs(int op, bit az, int step);
      if (step <= 2) begin
         cs_if.ir_opcode = 4'($urandom);
         cs_if.a_zero    = 1'($urandom);
      end else begin
         cs_if.ir_opcode = 4'(op);
         cs_if.a_zero    = az;
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [16:0] got;
      clr = 1'b1;
      cs_if.en = 1'b1;
      cs_if.ir_opcode = 4'h0;
      cs_if.a_zero = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      got = obs();
      checks++;
      if (got !== W_IDLE) begin
         $display("FAIL reset_idle got=%h exp=%h", got, W_IDLE);
         errors++;
      end
      next_cycle();
      clr = 1'b0;
      $display("reset: idle word checked");
   endtask

   task automatic test_instr(int op, bit az, string name);
      logic [16:0] got, e;
      for (int step = 1; step <= instr_len(op); step++) begin
         drive_inputs(op, az, step);
         @(negedge clk);
         got = obs();
         e = exp_word(op, step, az);
         checks++;
         if (got !== e) begin
            $display("FAIL %s op=%h step=%0d got=%h exp=%h", name, op, step, got, e);
            errors++;
         end
         next_cycle();
      end
      $display("%s op=%h az=%0d done in %0d cycles", name, op, az, instr_len(op));
   endtask

   task automatic test_reset_mid_instr();
      logic [16:0] got, e;
      for (int step = 1; step <= 3; step++) begin
         drive_inputs(1, 1'b0, step);
         next_cycle();
      end
      // Now in T4 of LDA.
      clr = 1'b1;
      @(negedge clk);
      got = obs();
      checks++;
      if (got !== W_IDLE) begin
         $display("FAIL reset_mid_idle got=%h exp=%h", got, W_IDLE);
         errors++;
      end
      next_cycle();
      clr = 1'b0;
      // Resume from T1 and complete as a NOP.
      for (int step = 1; step <= 3; step++) begin
         drive_inputs(0, 1'b0, step);
         @(negedge clk);
         got = obs();
         e = exp_word(0, step, 1'b0);
         checks++;
         if (got !== e) begin
            $display("FAIL reset_mid_resume step=%0d got=%h exp=%h", step, got, e);
            errors++;
         end
         next_cycle();
      end
      $display("reset_mid_instr: clr during LDA T4 recovered");
   endtask

   task automatic test_halt();
      logic [16:0] got, e;
      for (int step = 1; step <= 3; step++) begin
         drive_inputs(15, 1'b0, step);
         @(negedge clk);
         got = obs();
         e = exp_word(15, step, 1'b0);
         checks++;
         if (got !== e) begin
            $display("FAIL halt_fetch step=%0d got=%h exp=%h", step, got, e);
            errors++;
         end
         next_cycle();
      end
      for (int c = 0; c < 20; c++) begin
         cs_if.ir_opcode = 4'($urandom);
         cs_if.a_zero    = 1'($urandom);
         @(negedge clk);
         got = obs();
         checks++;
         if (got !== W_HALT) begin
            $display("FAIL halt_hold cycle=%0d got=%h exp=%h", c, got, W_HALT);
            errors++;
         end
         next_cycle();
      end
      clr = 1'b1;
      @(negedge clk);
      got = obs();
      checks++;
      if (got !== W_IDLE) begin
         $display("FAIL halt_clr got=%h exp=%h", got, W_IDLE);
         errors++;
      end
      next_cycle();
      clr = 1'b0;
      for (int step = 1; step <= 3; step++) begin
         drive_inputs(0, 1'b0, step);
         @(negedge clk);
         got = obs();
         e = exp_word(0, step, 1'b0);
         checks++;
         if (got !== e) begin
            $display("FAIL halt_exit step=%0d got=%h exp=%h", step, got, e);
            errors++;
         end
         next_cycle();
      end
      $display("halt: 20 halted cycles, clr exit checked");
   endtask

   task automatic test_stall_sub();
      logic [16:0] got, e;
      for (int step = 1; step <= 6; step++) begin
         drive_inputs(3, 1'b0, step);
         if (step == 5) begin
            for (int c = 0; c < 3; c++) begin
               cs_if.en = 1'b0;
               @(negedge clk);
               got = obs();
               checks++;
               if (got !== W_IDLE) begin
                  $display("FAIL stall_idle cycle=%0d got=%h exp=%h", c, got, W_IDLE);
                  errors++;
               end
               next_cycle();
            end
            cs_if.en = 1'b1;
         end
         @(negedge clk);
         got = obs();
         e = exp_word(3, step, 1'b0);
         checks++;
         if (got !== e) begin
            $display("FAIL stall_sub step=%0d got=%h exp=%h", step, got, e);
            errors++;
         end
         next_cycle();
      end
      $display("stall_sub: 3-cycle en=0 at T5 checked");
   endtask

   task automatic test_random(int n);
      logic [16:0] got, e;
      int op;
      bit az;
      for (int i = 0; i < n; i++) begin
         op = int'($urandom_range(0, 14));
         az = 1'($urandom);
         for (int step = 1; step <= instr_len(op); step++) begin
            drive_inputs(op, az, step);
            while ($urandom_range(0, 4) == 0) begin
               cs_if.en = 1'b0;
               @(negedge clk);
               got = obs();
               checks++;
               if (got !== W_IDLE) begin
                  $display("FAIL rand_stall i=%0d step=%0d got=%h exp=%h", i, step, got, W_IDLE);
                  errors++;
               end
               next_cycle();
            end
            cs_if.en = 1'b1;
            @(negedge clk);
            got = obs();
            e = exp_word(op, step, az);
            checks++;
            if (got !== e) begin
               $display("FAIL rand i=%0d op=%h az=%0d step=%0d got=%h exp=%h",
                        i, op, az, step, got, e);
               errors++;
            end
            next_cycle();
         end
         $display("rand %0d: op=%h az=%0d", i, op, az);
      end
   endtask

   initial begin
      test_reset();
      test_instr(1, 1'b0, "lda");
      test_instr(2, 1'b0, "add");
      test_instr(5, 1'b1, "div");
      test_instr(11, 1'b0, "jz_nz");
      test_instr(11, 1'b1, "jz_z");
      test_instr(8, 1'b0, "sta");
      test_instr(9, 1'b0, "out");
      test_instr(10, 1'b0, "jmp");
      test_instr(13, 1'b0, "reserved");
      test_reset_mid_instr();
      test_stall_sub();
      test_random(40);
      test_halt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
